// File: rtl/alkmdseq_if.sv
// alkmdseq_if: ALPCTL/handshake bundle between the microsequencer (master) and the ALK md sequencer (slave).
interface alkmdseq_if #(parameter int CNTW = 6);
  logic [9:0]      alpctl_in_h;
  logic            md_start_h;
  logic            md_div_h;
  logic            md_neg_h;
  logic            rem_neg_h;
  logic            q_zero_h;
  logic            md_abort_h;
  logic [9:0]      alpctl_h;
  logic            md_busy_h;
  logic            md_done_h;
  logic [CNTW-1:0] iter_cnt_h;
  modport master (
    output alpctl_in_h, md_start_h, md_div_h, md_neg_h, rem_neg_h, q_zero_h, md_abort_h,
    input  alpctl_h, md_busy_h, md_done_h, iter_cnt_h
  );
  modport slave (
    input  alpctl_in_h, md_start_h, md_div_h, md_neg_h, rem_neg_h, q_zero_h, md_abort_h,
    output alpctl_h, md_busy_h, md_done_h, iter_cnt_h
  );
endinterface

// File: rtl/alkmdseq.sv
// alkmdseq: ALK multiply/divide iteration sequencer (SETUP, ITER x LOOP, optional FIX, DONE).
// Optional multiply early termination on Q==0 is enabled by defining ALKMDSEQ_EARLY_TERM_EN.
module alkmdseq #(
  parameter int ITER = 32,
  parameter int CNTW = 6
) (
  input logic       qdclk_l,
  input logic       reset_l,
  alkmdseq_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] LOOP  = 3'd2;
  localparam logic [2:0] FIX   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]      state, state_nx;
  logic [CNTW-1:0] cnt, cnt_nx;
  logic            div_q, neg_q, fix_q, busy_q, done_q;
  logic            abort_hit, start_ok, last, early;
  logic [9:0]      op;
  assign abort_hit = bus.md_abort_h && state != IDLE;
  assign start_ok  = bus.md_start_h && !bus.md_abort_h && state == IDLE;
  assign last      = cnt == CNTW'(1);
`ifdef ALKMDSEQ_EARLY_TERM_EN
  assign early = state == LOOP && !div_q && bus.q_zero_h && cnt > CNTW'(1);
`else
  assign early = 1'b0;
`endif
  always_comb begin
    state_nx = abort_hit          ? IDLE :
               state == IDLE      ? (start_ok ? SETUP : IDLE) :
               state == SETUP     ? LOOP :
               state == LOOP      ? (early ? DONE : last ? (div_q ? FIX : DONE) : LOOP) :
               state == FIX       ? DONE : IDLE;
    cnt_nx   = (abort_hit || early) ? '0 :
               start_ok             ? CNTW'(ITER) :
               state == LOOP        ? cnt - CNTW'(1) : cnt;
  end
  always_ff @(posedge qdclk_l or negedge reset_l) begin
    if (!reset_l) begin
      state  <= IDLE;
      cnt    <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      fix_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      busy_q <= state_nx == SETUP || state_nx == LOOP || state_nx == FIX;
      done_q <= state_nx == DONE;
      if (start_ok) begin
        div_q <= bus.md_div_h;
        neg_q <= bus.md_neg_h;
        fix_q <= 1'b0;
      end
      if (state == LOOP && last) fix_q <= bus.rem_neg_h & div_q;
    end
  end
  // Op code is held constant across LOOP; the ALK alternates add/sub on its own.
  assign op = div_q ? (neg_q ? 10'h27C : 10'h26C) : (neg_q ? 10'h269 : 10'h279);
  assign bus.alpctl_h   = (state == SETUP || state == LOOP) ? op :
                          state == FIX ? (fix_q ? 10'h26A : {3'b000, bus.alpctl_in_h[6:0]}) :
                          bus.alpctl_in_h;
  assign bus.md_busy_h  = busy_q;
  assign bus.md_done_h  = done_q;
  assign bus.iter_cnt_h = cnt;
endmodule

// File: tb/tb_alkmdseq.sv
// tb_alkmdseq: directed scoreboard bench for alkmdseq; per-cycle expected outputs queued at stimulus time.
module tb_alkmdseq;
  localparam int ITER = 32;
  localparam int CNTW = 6;
`ifdef ALKMDSEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef struct packed {
    logic [9:0]      alp;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t sb[$];
  alkmdseq_if #(.CNTW(CNTW)) bus ();
  alkmdseq #(.ITER(ITER), .CNTW(CNTW)) dut (.qdclk_l(clk), .reset_l(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic [9:0] alp, input logic busy, input logic done, input int cnt);
    mk = '{alp: alp, busy: busy, done: done, cnt: CNTW'(cnt)};
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_alp"}, 16'(bus.alpctl_h), 16'(bus.alpctl_in_h));
    chk({tag, "_busy"}, 16'(bus.md_busy_h), 16'd0);
    chk({tag, "_done"}, 16'(bus.md_done_h), 16'd0);
    chk({tag, "_cnt"}, 16'(bus.iter_cnt_h), 16'd0);
  endtask
  // Called from inside an IDLE cycle; leaves the bench inside the trailing IDLE cycle.
  task automatic run_op(input string tag, input bit dv, input bit ng, input bit rn, input bit hold,
                        input int qz, input int ab);
    exp_t e;
    bit abt, et;
    int k;
    logic [9:0] opc, ain;
    abt = 1'b0;
    et = 1'b0;
    ain = 10'($urandom);
    opc = dv ? (ng ? 10'h27C : 10'h26C) : (ng ? 10'h269 : 10'h279);
    bus.alpctl_in_h = ain;
    bus.md_div_h = dv;
    bus.md_neg_h = ng;
    bus.md_start_h = 1'b1;
    bus.md_abort_h = 1'b0;
    bus.q_zero_h = 1'b0;
    bus.rem_neg_h = 1'b0;
    sb.push_back(mk(opc, 1'b1, 1'b0, ITER));
    for (int i = ITER; i >= 1; i--) begin
      sb.push_back(mk(opc, 1'b1, 1'b0, i));
      if (ab == i) begin abt = 1'b1; break; end
      if (EARLY && !dv && qz == i && i > 1) begin et = 1'b1; break; end
    end
    if (!abt) begin
      if (dv) sb.push_back(mk(rn ? 10'h26A : {3'b000, ain[6:0]}, 1'b1, 1'b0, 0));
      sb.push_back(mk(ain, 1'b0, 1'b1, 0));
    end
    sb.push_back(mk(ain, 1'b0, 1'b0, 0));
    if (abt) sb.push_back(mk(ain, 1'b0, 1'b0, 0));
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk);
      #1;
      k++;
      bus.md_start_h = hold;
      bus.md_div_h = ~dv;
      bus.md_neg_h = ~ng;
      bus.rem_neg_h = (k == ITER + 1) ? rn : ~rn;
      bus.q_zero_h = qz != 0 && k == ITER + 2 - qz;
      bus.md_abort_h = ab != 0 && k == ITER + 2 - ab;
      #1;
      chk($sformatf("%s_c%0d_alp", tag, k), 16'(bus.alpctl_h), 16'(e.alp));
      chk($sformatf("%s_c%0d_busy", tag, k), 16'(bus.md_busy_h), 16'(e.busy));
      chk($sformatf("%s_c%0d_done", tag, k), 16'(bus.md_done_h), 16'(e.done));
      chk($sformatf("%s_c%0d_cnt", tag, k), 16'(bus.iter_cnt_h), 16'(e.cnt));
    end
    bus.md_abort_h = 1'b0;
    bus.q_zero_h = 1'b0;
  endtask
  initial begin
    bus.alpctl_in_h = 10'h155;
    bus.md_start_h = 1'b0;
    bus.md_div_h = 1'b0;
    bus.md_neg_h = 1'b0;
    bus.rem_neg_h = 1'b0;
    bus.q_zero_h = 1'b0;
    bus.md_abort_h = 1'b0;
    #3;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    run_op("mulp", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op("muln", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    run_op("divn_fix", 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    run_op("divp_nofix", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op("abort_mul", 1'b0, 1'b0, 1'b0, 1'b0, 0, 10);
    run_op("abort_div", 1'b1, 1'b1, 1'b1, 1'b0, 0, 10);
    run_op("hold_a", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    run_op("hold_b", 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    run_op("qz_mul", 1'b0, 1'b0, 1'b0, 1'b0, 20, 0);
    run_op("qz_div", 1'b1, 1'b0, 1'b1, 1'b0, 20, 0);
    bus.md_start_h = 1'b1;
    bus.md_abort_h = 1'b1;
    @(posedge clk);
    #1;
    bus.md_start_h = 1'b0;
    bus.md_abort_h = 1'b0;
    #1;
    chk_idle("start_abort_idle");
    bus.md_abort_h = 1'b1;
    @(posedge clk);
    #1;
    bus.md_abort_h = 1'b0;
    #1;
    chk_idle("abort_idle");
    bus.alpctl_in_h = 10'h2A3;
    bus.md_div_h = 1'b1;
    bus.md_start_h = 1'b1;
    @(posedge clk);
    #1;
    bus.md_start_h = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", 16'(bus.md_busy_h), 16'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk_idle("post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
